// File: rtl/spi_master.sv
// rtl/spi_master.sv - Mode-0 MSB-first SPI master, one full-duplex word per start
module spi_master #(
  parameter int CLK_DIV    = 6,
  parameter int CS_GAP     = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ce0
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  miso_meta;
  logic                  miso_s;

  // miso comes from off-chip with no relation to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_s    <= miso_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ce0     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh   <= tx_data << 1;
            mosi    <= tx_data[DATA_WIDTH-1];
            ce0     <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= LEAD;
          end
        end

        // setup time from ce0 falling to the first rising sclk edge
        LEAD: begin
          if (cnt == DIV_LAST) begin
            sclk  <= 1'b1;
            rx_sh <= (rx_sh << 1) | DATA_WIDTH'(miso_s);
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= TRAIL;
              end else begin
                mosi    <= tx_sh[DATA_WIDTH-1];
                tx_sh   <= tx_sh << 1;
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              sclk  <= 1'b1;
              rx_sh <= (rx_sh << 1) | DATA_WIDTH'(miso_s);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // hold time after the last falling edge before ce0 releases
        TRAIL: begin
          if (cnt == DIV_LAST) begin
            ce0     <= 1'b1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
            cnt     <= '0;
            if (CS_GAP == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
